// File: rtl/load_align_pkg.sv
// Shared load-alignment definitions: funct3 codes, FSM state encoding, size and legality decode.
// No logic of its own.
// Used by load_align_unit and load_extract.
package load_align_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESP
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

  // Doubleword loads exist only on a 64-bit datapath.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is64);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      F3_LD, F3_LWU:                       return is64;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Purpose: select the addressed byte/half/word/dword from {beat1,beat0} and sign/zero extend it.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module load_extract
  import load_align_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] beat0,
  input  logic [XLEN-1:0] beat1,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            msb;
  logic            ext;

  always_comb begin
    shifted   = XLEN'({beat1, beat0} >> {offset, 3'b000});
    keep_mask = '1;
    msb       = shifted[XLEN-1];
    case (funct3[1:0])
      2'd0: begin keep_mask = XLEN'(8'hFF);          msb = shifted[7];  end
      2'd1: begin keep_mask = XLEN'(16'hFFFF);       msb = shifted[15]; end
      2'd2: begin keep_mask = XLEN'(32'hFFFF_FFFF);  msb = shifted[31]; end
      default: ;
    endcase
    ext    = !funct3[2] && msb;
    result = (shifted & keep_mask) | (ext ? ~keep_mask : '0);
  end

endmodule

// File: rtl/load_align_unit.sv
// Purpose: one-outstanding load unit issuing aligned beats and returning an extended result; MISALIGNED_SPLIT_EN enables two-beat misaligned loads.
// Latency: accept->resp_valid 3 cycles per aligned single beat on zero-wait memory, 1 cycle on faults.
// Backpressure: mem_req_valid/addr held until mem_req_ready; resp held until resp_ready; req_ready only in IDLE.
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_fault
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      f3_q;
  logic            fault_q;
  logic [XLEN-1:0] beat0_q;
  logic [XLEN-1:0] beat1_q;
  logic [XLEN-1:0] beat_addr;
  logic [XLEN-1:0] ext_result;
  logic            req_fault;

`ifdef MISALIGNED_SPLIT_EN
  logic cross;
  assign req_fault = !funct3_legal(req_funct3, XLEN == 64);
  assign cross     = (5'(addr_q[OFFW-1:0]) + 5'(size_bytes(f3_q[1:0]))) > 5'(BYTES);
`else
  logic [3:0] req_size;
  logic       req_misal;
  assign req_size  = size_bytes(req_funct3[1:0]);
  assign req_misal = (req_addr[OFFW-1:0] & OFFW'(req_size - 4'd1)) != '0;
  assign req_fault = !funct3_legal(req_funct3, XLEN == 64) || req_misal;
  assign beat1_q   = '0;
`endif

  assign beat_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      fault_q <= 1'b0;
      beat0_q <= '0;
`ifdef MISALIGNED_SPLIT_EN
      beat1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          f3_q    <= req_funct3;
          fault_q <= req_fault;
          beat0_q <= '0;
`ifdef MISALIGNED_SPLIT_EN
          beat1_q <= '0;
`endif
        end
        ST_WAIT0: if (mem_resp_valid) beat0_q <= mem_resp_data;
`ifdef MISALIGNED_SPLIT_EN
        ST_WAIT1: if (mem_resp_valid) beat1_q <= mem_resp_data;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    resp_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_fault ? ST_RESP : ST_ISSUE0;
      end
      ST_ISSUE0: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = beat_addr;
        if (mem_req_ready) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
`ifdef MISALIGNED_SPLIT_EN
        if (mem_resp_valid) state_d = cross ? ST_ISSUE1 : ST_RESP;
`else
        if (mem_resp_valid) state_d = ST_RESP;
`endif
      end
`ifdef MISALIGNED_SPLIT_EN
      ST_ISSUE1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = beat_addr + XLEN'(BYTES);
        if (mem_req_ready) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_resp_valid) state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .beat0  (beat0_q),
    .beat1  (beat1_q),
    .offset (addr_q[OFFW-1:0]),
    .funct3 (f3_q),
    .result (ext_result)
  );

  // Outputs derive from held registers, so they stay stable for the whole RESP state.
  assign resp_data  = (state_q == ST_RESP && !fault_q) ? ext_result : '0;
  assign resp_fault = (state_q == ST_RESP) && fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit (XLEN=32): directed and random loads against a byte-level memory model.
module tb_load_align_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_funct3;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_fault;

  always #5 clk = ~clk;

  load_align_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_fault(resp_fault)
  );

  int n_vec = 0;
  int n_err = 0;
  int mem_stall_cfg = 0;
  int stray_req = 0;
  int beat_cnt = 0;
  int addr_moved = 0;
  logic [31:0] beat_log [4];
  logic [31:0] mem_img [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00}) >> {a[1:0], 3'b000};
    return w[7:0];
  endfunction

  // Reference: gather the S addressed bytes one at a time, then extend.
  task automatic model_load(input logic [31:0] addr, input logic [2:0] f3,
                            output logic [31:0] data, output logic fault, output int beats);
    int size;
    logic legal, misal;
    logic [63:0] val, tmp;
    size  = 1 << f3[1:0];
    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
    misal = (addr % size) != 0;
    fault = !legal;
`ifndef MISALIGNED_SPLIT_EN
    if (misal) fault = 1'b1;
`endif
    data  = '0;
    beats = 0;
    if (!fault) begin
      beats = ((addr % 4) + size > 4) ? 2 : 1;
      val = '0;
      for (int k = 0; k < size; k++) val |= 64'(mem_byte(addr + 32'(k))) << (8 * k);
      tmp = val >> (8 * size - 1);
      if (!f3[2] && size < 4 && tmp[0]) val |= ~((64'd1 << (8 * size)) - 64'd1);
      data = val[31:0];
    end
  endtask

  // Memory: ready after mem_stall_cfg cycles of a pending beat, data one cycle after acceptance.
  initial begin
    logic pending, have_prev;
    logic [31:0] pending_data, prev_addr;
    int ctr, stray_seen;
    pending = 0; have_prev = 0; pending_data = '0; prev_addr = '0; ctr = 0; stray_seen = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = pending;
      mem_resp_data  = pending_data;
      pending = 0;
      if (stray_seen != stray_req) begin
        stray_seen = stray_req;
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
      end
      if (mem_req_valid) begin
        if (have_prev && mem_req_addr !== prev_addr) addr_moved++;
        if (ctr >= mem_stall_cfg) begin
          mem_req_ready = 1'b1;
          pending = 1'b1;
          pending_data = mem_word(mem_req_addr);
          beat_log[beat_cnt % 4] = mem_req_addr;
          beat_cnt++;
          ctr = 0;
          have_prev = 0;
        end else begin
          mem_req_ready = 1'b0;
          ctr++;
          have_prev = 1;
          prev_addr = mem_req_addr;
        end
      end else begin
        if (have_prev) addr_moved++;
        mem_req_ready = 1'b0;
        have_prev = 0;
      end
    end
  end

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input int mstall, input int rstall,
                         output logic [31:0] data, output logic fault, output int lat, output int beats,
                         output logic [31:0] b0addr, output logic held_ok);
    int start;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    start = beat_cnt;
    mem_stall_cfg = mstall;
    req_valid = 1'b1; req_addr = addr; req_funct3 = f3; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    data = resp_data; fault = resp_fault; held_ok = resp_valid;
    for (int i = 0; i < rstall; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== data || resp_fault !== fault) held_ok = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    beats  = beat_cnt - start;
    b0addr = beat_log[start % 4];
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 0; req_addr = '0; req_funct3 = '0; resp_ready = 0;
    repeat (3) @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid got %b want 0", mem_req_valid); end
    n_vec++; if (mem_req_addr !== '0) begin n_err++; $display("FAIL reset_mem_req_addr got %h want 0", mem_req_addr); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_vec++; if (resp_data !== '0 || resp_fault !== 1'b0) begin n_err++; $display("FAIL reset_resp got %h/%b want 0/0", resp_data, resp_fault); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] a [5] = '{32'h103, 32'h102, 32'h102, 32'h8, 32'h10};
    logic [2:0]  f [5] = '{3'b000, 3'b101, 3'b001, 3'b011, 3'b110};
    logic [31:0] w [5] = '{32'h80FF_1234, 32'hBEEF_0000, 32'hBEEF_0000, 32'h1111_1111, 32'h2222_2222};
    logic [31:0] ed [5] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0, 32'h0};
    logic        ef [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int          el [5] = '{3, 3, 3, 1, 1};
    int          eb [5] = '{1, 1, 1, 0, 0};
    logic [31:0] d, b0; logic flt, held; int lat, nb;
    for (int i = 0; i < 5; i++) begin
      mem_img[{a[i][31:2], 2'b00}] = w[i];
      do_load(a[i], f[i], 0, 0, d, flt, lat, nb, b0, held);
      n_vec++; if (d !== ed[i] || flt !== ef[i]) begin n_err++; $display("FAIL directed%0d_data got %h/%b want %h/%b", i, d, flt, ed[i], ef[i]); end
      n_vec++; if (lat !== el[i] || nb !== eb[i]) begin n_err++; $display("FAIL directed%0d_timing got lat %0d beats %0d want %0d/%0d", i, lat, nb, el[i], eb[i]); end
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] a [3] = '{32'h203, 32'h201, 32'hFFFF_FFFE};
    logic [2:0]  f [3] = '{3'b010, 3'b001, 3'b010};
    logic [31:0] d, b0, md; logic flt, held, mf; int lat, nb, mb, el;
    mem_img[32'h200] = 32'hDDCC_BBAA;
    mem_img[32'h204] = 32'h4433_2211;
    for (int i = 0; i < 3; i++) begin
      model_load(a[i], f[i], md, mf, mb);
      el = mf ? 1 : (mb == 1 ? 3 : 5);
      do_load(a[i], f[i], 0, 0, d, flt, lat, nb, b0, held);
      n_vec++; if (d !== md || flt !== mf) begin n_err++; $display("FAIL misal%0d_data got %h/%b want %h/%b", i, d, flt, md, mf); end
      n_vec++; if (lat !== el || nb !== mb) begin n_err++; $display("FAIL misal%0d_timing got lat %0d beats %0d want %0d/%0d", i, lat, nb, el, mb); end
      if (nb > 0) begin
        n_vec++; if (b0 !== {a[i][31:2], 2'b00}) begin n_err++; $display("FAIL misal%0d_beat0_addr got %h want %h", i, b0, {a[i][31:2], 2'b00}); end
      end
    end
    // Hand-computed expectation for the canonical crossing load.
    do_load(32'h203, 3'b010, 0, 0, d, flt, lat, nb, b0, held);
`ifdef MISALIGNED_SPLIT_EN
    n_vec++; if (d !== 32'h3322_11DD || flt !== 1'b0 || nb !== 2) begin n_err++; $display("FAIL split_lw got %h/%b beats %0d want 332211dd/0/2", d, flt, nb); end
`else
    n_vec++; if (d !== 32'h0 || flt !== 1'b1 || nb !== 0 || lat !== 1) begin n_err++; $display("FAIL split_lw got %h/%b beats %0d lat %0d want 0/1/0/1", d, flt, nb, lat); end
`endif
  endtask

  task automatic test_backpressure;
    logic [31:0] d, b0; logic flt, held; int lat, nb, moved0;
    mem_img[32'h300] = 32'h1234_5678;
    moved0 = addr_moved;
    do_load(32'h300, 3'b010, 3, 2, d, flt, lat, nb, b0, held);
    n_vec++; if (d !== 32'h1234_5678 || flt !== 1'b0) begin n_err++; $display("FAIL bp_data got %h/%b want 12345678/0", d, flt); end
    n_vec++; if (lat !== 6 || nb !== 1) begin n_err++; $display("FAIL bp_timing got lat %0d beats %0d want 6/1", lat, nb); end
    n_vec++; if (addr_moved !== moved0) begin n_err++; $display("FAIL bp_addr_hold got %0d changes want %0d", addr_moved, moved0); end
    n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL bp_resp_hold got %b want 1", held); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, b0, md; logic flt, held, mf; int lat, nb, mb;
    mem_stall_cfg = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_funct3 = 3'b010; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL mid_wait0 got mreq %b rdy %b want 0/0", mem_req_valid, req_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stray_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_idle%0d got rv %b rdy %b mreq %b want 0/1/0", i, resp_valid, req_ready, mem_req_valid);
      end
    end
    model_load(32'h44, 3'b001, md, mf, mb);
    do_load(32'h44, 3'b001, 0, 0, d, flt, lat, nb, b0, held);
    n_vec++; if (d !== md || flt !== mf || lat !== 3) begin n_err++; $display("FAIL mid_recover got %h/%b lat %0d want %h/%b lat 3", d, flt, lat, md, mf); end
  endtask

  task automatic test_random;
    logic [31:0] addr, d, b0, md; logic [2:0] f3; logic flt, held, mf; int lat, nb, mb, ms, rs, el;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(1 << f3[1:0]) - 32'd1);
      ms = $urandom_range(0, 2);
      rs = $urandom_range(0, 2);
      model_load(addr, f3, md, mf, mb);
      el = mf ? 1 : (mb == 1 ? 3 + ms : 5 + 2 * ms);
      do_load(addr, f3, ms, rs, d, flt, lat, nb, b0, held);
      n_vec++; if (d !== md || flt !== mf) begin n_err++; $display("FAIL rand%0d_data a=%h f3=%0d got %h/%b want %h/%b", i, addr, f3, d, flt, md, mf); end
      n_vec++; if (lat !== el || nb !== mb) begin n_err++; $display("FAIL rand%0d_timing got lat %0d beats %0d want %0d/%0d", i, lat, nb, el, mb); end
      n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL rand%0d_resp_hold got %b want 1", i, held); end
      if (nb > 0) begin
        n_vec++; if (b0 !== {addr[31:2], 2'b00}) begin n_err++; $display("FAIL rand%0d_beat0_addr got %h want %h", i, b0, {addr[31:2], 2'b00}); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_misaligned;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
